// File: rtl/uart_tx_tick_if.sv
// Handshake bundle between a frame producer and uart_tx_tick.
// The producer drives payload/request; the transmitter reports busy/done.
`timescale 1ns/1ps
interface uart_tx_tick_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_start;
  logic                  o_busy;
  logic                  o_done;

  modport master (output i_data, output i_start, input  o_busy, input  o_done);
  modport slave  (input  i_data, input  i_start, output o_busy, output o_done);
endinterface

// File: rtl/uart_tx_tick.sv
// UART transmitter advanced by ticks edge-detected from an asynchronous baud square wave.
// Frame: start, LSB-first data, optional parity, 1 or 2 stop bits; o_tx is registered.
`timescale 1ns/1ps
module uart_tx_tick #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_baud_clk,
  uart_tx_tick_if.slave  bus,
  output logic           o_tx
);

  localparam int                CNT_W     = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic              LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            sync_q, sync_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick;

  // sync_q[1:0] is the two-flop synchroniser; sync_q[2] is the edge-detect delay.
  always_comb begin
    sync_d = {sync_q[1:0], i_baud_clk};
  end

  assign tick = sync_q[1] & ~sync_q[2];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      // NOTE: the shift register is a plain register, not a memory, so it is safe and cheap to reset.
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Accepting does not look at tick: a coincident tick is absorbed by ALIGN.
        if (bus.i_start) begin
          shreg_d  = bus.i_data;
          parity_d = 1'b0;
          state_d  = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (tick) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_d   = shreg_q >> 1;
          parity_d  = parity_q ^ shreg_q[0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            stop_cnt_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is derived from the next state so o_tx moves on the tick edge itself.
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = parity_d ^ (PARITY_ODD != 0);
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_tx       = tx_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

endmodule
